// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter with runtime modulus, parallel load,
// wrap/saturate boundaries, terminal-count pulse and sticky flags.
module up_down_counter_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] max_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic             zero
);

    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             ovf_evt;
    logic             unf_evt;
    logic             at_top;
    logic             at_zero;
    logic             above_max;
    logic [WIDTH-1:0] load_clamp;

    // Compare before stepping so no intermediate exceeds WIDTH bits.
    assign at_top     = (count_q >= max_val);
    assign above_max  = (count_q > max_val);
    assign at_zero    = (count_q == '0);
    assign load_clamp = (load_val > max_val) ? max_val : load_val;

    always_comb begin
        count_d = count_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (load) begin
            count_d = load_clamp;
        end else if (en && up_dn) begin
            if (at_top) begin
                ovf_evt = 1'b1;
                count_d = sat_mode ? max_val : '0;
            end else begin
                count_d = count_q + ONE;
            end
        end else if (en) begin
            if (at_zero) begin
                unf_evt = 1'b1;
                count_d = sat_mode ? '0 : max_val;
            end else if (above_max) begin
                count_d = max_val;
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    // A same-edge event beats clr_flags for its own flag.
    always_comb begin
        tc_d  = ovf_evt | unf_evt;
        ovf_d = ovf_evt | (ovf_q & ~clr_flags);
        unf_d = unf_evt | (unf_q & ~clr_flags);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RST_CNT;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count_out = count_q;
    assign tc        = tc_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign zero      = at_zero;

endmodule

// File: tb/tb_up_down_counter_param.sv
// Scoreboard bench: driver pushes model expectations, monitor pops
// and compares after every rising edge.
module tb_up_down_counter_param;

    localparam int W    = 8;
    localparam int RVAL = 3;

    logic         clk;
    logic         reset;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic         sat_mode;
    logic [W-1:0] max_val;
    logic         clr_flags;
    logic [W-1:0] count_out;
    logic         tc;
    logic         ovf;
    logic         unf;
    logic         zero;

    up_down_counter_param #(
        .WIDTH(W),
        .RESET_VAL(RVAL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .up_dn(up_dn),
        .load(load),
        .load_val(load_val),
        .sat_mode(sat_mode),
        .max_val(max_val),
        .clr_flags(clr_flags),
        .count_out(count_out),
        .tc(tc),
        .ovf(ovf),
        .unf(unf),
        .zero(zero)
    );

    typedef struct {
        int cnt;
        bit tc;
        bit ovf;
        bit unf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    int m_cnt;
    bit m_tc;
    bit m_ovf;
    bit m_unf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_cnt = RVAL;
        m_tc  = 0;
        m_ovf = 0;
        m_unf = 0;
    endfunction

    // Behavioural rules in plain integer arithmetic.
    function automatic void model_step(
        bit e, bit u, bit ld, int lv, bit s, int mx, bit c);
        bit oe = 0;
        bit ue = 0;
        if (ld) begin
            m_cnt = (lv < mx) ? lv : mx;
        end else if (e && u) begin
            if (m_cnt >= mx) begin
                oe = 1;
                m_cnt = s ? mx : 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else if (e) begin
            if (m_cnt == 0) begin
                ue = 1;
                m_cnt = s ? 0 : mx;
            end else if (m_cnt > mx) begin
                m_cnt = mx;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        m_tc  = oe | ue;
        m_ovf = oe | (m_ovf & !c);
        m_unf = ue | (m_unf & !c);
    endfunction

    function automatic void push_exp();
        exp_t x;
        x.cnt = m_cnt;
        x.tc  = m_tc;
        x.ovf = m_ovf;
        x.unf = m_unf;
        q.push_back(x);
    endfunction

    task automatic drive(input bit e, input bit u, input bit ld,
                         input int lv, input bit s, input int mx,
                         input bit c);
        @(negedge clk);
        reset     = 1'b1;
        en        = e;
        up_dn     = u;
        load      = ld;
        load_val  = W'(lv);
        sat_mode  = s;
        max_val   = W'(mx);
        clr_flags = c;
        model_step(e, u, ld, lv, s, mx, c);
        push_exp();
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b0;
            model_reset();
            push_exp();
        end
    endtask

    // Reset asserted between edges must clear outputs at once.
    task automatic async_reset();
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_cnt", int'(count_out), RVAL);
        check("async_tc", int'(tc), 0);
        check("async_ovf", int'(ovf), 0);
        check("async_unf", int'(unf), 0);
        model_reset();
        push_exp();
        hold_reset(1);
    endtask

    // Monitor: one expectation per rising edge once stimulus starts.
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("count", int'(count_out), x.cnt);
                check("tc", int'(tc), int'(x.tc));
                check("ovf", int'(ovf), int'(x.ovf));
                check("unf", int'(unf), int'(x.unf));
                check("zero", int'(zero), int'(x.cnt == 0));
            end
        end
    end

    initial begin : stim
        int mx;
        int wait_cyc;
        reset     = 1'b0;
        en        = 1'b0;
        up_dn     = 1'b0;
        load      = 1'b0;
        load_val  = '0;
        sat_mode  = 1'b0;
        max_val   = '0;
        clr_flags = 1'b0;
        model_reset();
        hold_reset(2);

        // wrap up through max_val=5
        drive(0, 1, 1, 0, 0, 5, 0);
        for (int i = 0; i < 8; i++) drive(1, 1, 0, 0, 0, 5, 0);
        // wrap down from 2
        drive(0, 0, 1, 2, 0, 5, 0);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 5, 0);
        // saturate near 200
        drive(0, 1, 1, 198, 1, 200, 1);
        for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 1, 200, 0);
        drive(0, 0, 1, 0, 1, 200, 0);
        for (int i = 0; i < 2; i++) drive(1, 0, 0, 0, 1, 200, 0);
        // load clamp, then max_val lowered below count
        drive(0, 0, 1, 250, 0, 100, 1);
        drive(1, 0, 0, 0, 0, 50, 0);
        // clr_flags with an underflow on the same edge
        drive(1, 1, 0, 0, 1, 50, 0);
        drive(0, 0, 1, 0, 0, 50, 0);
        drive(1, 0, 0, 0, 0, 50, 1);
        // load beats enable
        drive(1, 1, 1, 17, 0, 50, 0);
        // max_val == 0 in both modes
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 1, 0, 0);
        // count=37, ovf=1, then asynchronous reset
        drive(0, 1, 1, 100, 0, 100, 1);
        drive(1, 1, 0, 0, 0, 100, 0);
        drive(0, 1, 1, 37, 0, 100, 0);
        async_reset();
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 100, 0);

        mx = 5;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0)
                mx = ($urandom_range(0, 7) == 0) ?
                     int'($urandom_range(0, 255)) :
                     int'($urandom_range(0, 6));
            if ($urandom_range(0, 150) == 0) begin
                async_reset();
            end else begin
                drive($urandom_range(0, 5) != 0,
                      $urandom_range(0, 1) == 1,
                      $urandom_range(0, 11) == 0,
                      int'($urandom_range(0, 255)),
                      $urandom_range(0, 1) == 1,
                      mx,
                      $urandom_range(0, 9) == 0);
            end
        end

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
